// File: rtl/jtframe_scroll_tiles.sv
// 16x16 tile scroll layer: dual-port map VRAM, independent h/v scroll, 8-pixel groups
// fetched from graphics ROM. Define JTFRAME_SCROLL_ROWSCR_EN for per-row horizontal scroll.
module jtframe_scroll_tiles #(
    parameter int HW         = 9,
    parameter int VW         = 8,
    parameter int MAPAW      = 10,
    parameter int CODEW      = 11,
    parameter int PALW       = 3,
    parameter     SIMFILE_LO = "scr_lo.bin",
    parameter     SIMFILE_HI = "scr_hi.bin"
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               pxl_cen,
    input  logic               flip,
    input  logic [HW-1:0]      h,
    input  logic [VW-1:0]      v,
    input  logic [HW:0]        hscr,
    input  logic [VW-1:0]      vscr,
    input  logic [MAPAW:0]     cpu_addr,
    input  logic               scr_cs,
    input  logic               cpu_wrn,
    input  logic [7:0]         cpu_dout,
    output logic [7:0]         cpu_din,
    output logic [CODEW+4:0]   rom_addr,
    output logic               rom_cs,
    input  logic [31:0]        rom_data,
    input  logic               rom_ok,
    output logic [PALW+3:0]    pxl,
    output logic               miss
);

localparam int ROWW = VW-4;
localparam int COLW = MAPAW-ROWW;

logic [7:0]       ram_lo [0:2**MAPAW-1];
logic [7:0]       ram_hi [0:2**MAPAW-1];
logic [HW:0]      hscr_eff, hsum;
logic [HW-3:0]    grp_next;
logic [VW-1:0]    vsum;
logic [MAPAW-1:0] map_addr, cpu_waddr;
logic [CODEW-1:0] scan_code;
logic [PALW-1:0]  scan_pal, next_pal, pal;
logic [31:0]      shifter;
logic             cpu_we;

assign cpu_we    = scr_cs & ~cpu_wrn;
assign cpu_waddr = cpu_addr[MAPAW-1:0];

// Preload images are only consumed by simulation wrappers around this block
if (SIMFILE_LO == "" || SIMFILE_HI == "") begin : g_no_preload
end

`ifdef JTFRAME_SCROLL_ROWSCR_EN
logic [HW:0] rs_ram [0:2**ROWW-1];
logic [HW:0] rs_hscr;
logic [7:0]  rs_lo;
logic [15:0] rs_wdata;
logic        rs_sel;

// Top 2^ROWW words: low-lane write stages the low byte, high-lane write commits the entry
assign rs_sel   = &cpu_addr[MAPAW-1:ROWW];
assign rs_wdata = {cpu_dout, rs_lo};

always_ff @(posedge clk) begin
    if (cpu_we && rs_sel) begin
        if (cpu_addr[MAPAW]) rs_ram[cpu_addr[ROWW-1:0]] <= rs_wdata[HW:0];
        else                 rs_lo <= cpu_dout;
    end
end

always_ff @(posedge clk or posedge rst) begin
    if (rst)                               rs_hscr <= '0;
    else if (pxl_cen && hsum[2:0] == 3'd0) rs_hscr <= rs_ram[vsum[VW-1:4]];
end

assign hscr_eff = hscr + rs_hscr;
`else
assign hscr_eff = hscr;
`endif

assign hsum     = {h[HW-1], h} + hscr_eff - (flip ? {(HW+1){1'b0}} : {1'b1, {HW{1'b0}}});
assign grp_next = hsum[HW:3] + {{(HW-3){1'b0}}, 1'b1};
assign vsum     = v + vscr;
assign map_addr = {vsum[VW-1:4], grp_next[COLW:1]};

// Read-before-write: a scan read colliding with a CPU write sees the old word
always_ff @(posedge clk) begin
    if (cpu_we) begin
        if (cpu_addr[MAPAW]) ram_hi[cpu_waddr] <= cpu_dout;
        else                 ram_lo[cpu_waddr] <= cpu_dout;
    end
    cpu_din <= cpu_addr[MAPAW] ? ram_hi[cpu_waddr] : ram_lo[cpu_waddr];
    if (pxl_cen && hsum[2:0] == 3'd0) begin
        scan_code <= {ram_hi[map_addr][CODEW-9:0], ram_lo[map_addr]};
        scan_pal  <= ram_hi[map_addr][7:8-PALW];
    end
end

always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
        pxl      <= '0;
        rom_cs   <= 1'b0;
        rom_addr <= '0;
        miss     <= 1'b0;
        shifter  <= '0;
        next_pal <= '0;
        pal      <= '0;
    end else if (pxl_cen) begin
        pxl <= {pal, flip ? shifter[31:28] : shifter[3:0]};
        if (hsum[2:0] == 3'd7) begin
            shifter <= rom_ok ? rom_data : 32'd0;
            miss    <= miss | ~rom_ok;
            pal     <= next_pal;
            rom_cs  <= 1'b0;
        end else begin
            shifter <= flip ? {shifter[27:0], 4'd0} : {4'd0, shifter[31:4]};
        end
        if (hsum[2:0] == 3'd1) begin
            next_pal <= scan_pal;
            rom_addr <= {scan_code, grp_next[0], vsum[3:0]};
            rom_cs   <= 1'b1;
        end
        // a phase jump that skips LOAD must not leave a stale request up
        if (hsum[2:0] == 3'd0) rom_cs <= 1'b0;
    end
end

endmodule

// File: tb/tb_jtframe_scroll_tiles.sv
// Bench for jtframe_scroll_tiles: pixel-level reference model feeding a scoreboard queue.
module tb_jtframe_scroll_tiles;

logic        clk = 1'b0;
logic        rst, pxl_cen, flip, scr_cs, cpu_wrn, rom_cs, rom_ok, miss;
logic [8:0]  h;
logic [7:0]  v, vscr, cpu_dout, cpu_din;
logic [9:0]  hscr;
logic [10:0] cpu_addr;
logic [15:0] rom_addr;
logic [31:0] rom_data;
logic [6:0]  pxl;

logic        rom_hash;
logic        ok_cur;
logic [6:0]  last_pxl;
logic [15:0] map_m [0:1023];
logic [6:0]  sb [$];
int          checks = 0;
int          errors = 0;

typedef struct {
    logic       flip;
    logic [9:0] hscr;
    logic [7:0] vscr;
    logic [7:0] v;
    logic [8:0] h0;
    logic       hash;
    logic       exp_miss;
} vec_t;

vec_t vecs [6];

always #5 clk = ~clk;

assign rom_data = rom_hash ? ({rom_addr, ~rom_addr} ^ 32'h5A3C96E1) : 32'h76543210;

jtframe_scroll_tiles dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip), .h(h), .v(v),
    .hscr(hscr), .vscr(vscr), .cpu_addr(cpu_addr), .scr_cs(scr_cs),
    .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .pxl(pxl), .miss(miss)
);

task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
endtask

function automatic logic [9:0] hsum_f(input logic [8:0] hh, input logic [9:0] sc, input logic fl);
    logic [9:0] he;
    he = {hh[8], hh};
    return he + sc - (fl ? 10'd0 : 10'd512);
endfunction

function automatic logic [31:0] rom_f(input logic hs, input logic [15:0] a);
    return hs ? ({a, ~a} ^ 32'h5A3C96E1) : 32'h76543210;
endfunction

function automatic logic [15:0] fetch_addr(input logic [9:0] s, input logic [7:0] vs);
    logic [15:0] m;
    m = map_m[{vs[7:4], s[9:4]}];
    return {m[10:0], s[3], vs[3:0]};
endfunction

// One pixel: drive at negedge, DUT samples at posedge, compare at the next negedge
task automatic pix_step(input bit chk);
    logic [9:0]  x, s;
    logic [7:0]  vs;
    logic [15:0] m;
    logic [31:0] rd;
    logic [2:0]  n;
    logic [3:0]  colr;
    logic [6:0]  e;
    x  = hsum_f(h, hscr, flip);
    vs = v + vscr;
    s  = {x[9:3], 3'b000};
    m  = map_m[{vs[7:4], s[9:4]}];
    rd = rom_f(rom_hash, fetch_addr(s, vs));
    n  = flip ? 3'd7 - x[2:0] : x[2:0];
    colr = ok_cur ? rd[int'(n)*4 +: 4] : 4'd0;
    e  = {m[15:13], colr};
    if (chk) begin
        sb.push_back(e);
        if (x[2:0] >= 3'd2) begin
            check("rom_addr", {16'd0, rom_addr}, {16'd0, fetch_addr(s + 10'd8, vs)});
            check("rom_cs", {31'd0, rom_cs}, 32'd1);
        end
    end
    if (x[2:0] == 3'd7) ok_cur = rom_ok;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen  = 1'b0;
    last_pxl = pxl;
    if (sb.size() > 0) check("pxl", {25'd0, pxl}, {25'd0, sb.pop_front()});
    @(negedge clk);
    h = h + 9'd1;
endtask

task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; scr_cs = 1'b1; cpu_wrn = 1'b0;
    @(negedge clk);
    scr_cs = 1'b0; cpu_wrn = 1'b1;
endtask

task automatic cpu_read(input logic [10:0] a, output logic [7:0] d);
    cpu_addr = a; scr_cs = 1'b1; cpu_wrn = 1'b1;
    @(negedge clk);
    d = cpu_din;
    scr_cs = 1'b0;
endtask

initial begin
    logic [7:0]  rb;
    logic [8:0]  hh;
    logic [15:0] w;
    rst = 1'b1; pxl_cen = 1'b0; flip = 1'b0; h = '0; v = '0; hscr = '0; vscr = '0;
    cpu_addr = '0; scr_cs = 1'b0; cpu_wrn = 1'b1; cpu_dout = '0;
    rom_ok = 1'b1; rom_hash = 1'b0; ok_cur = 1'b1; last_pxl = '0;

    vecs[0] = '{1'b0, 10'd480,  8'h00, 8'h00, 9'd0,   1'b0, 1'b0};
    vecs[1] = '{1'b1, 10'd992,  8'h00, 8'h00, 9'd0,   1'b0, 1'b0};
    vecs[2] = '{1'b0, 10'd488,  8'h00, 8'h00, 9'd0,   1'b1, 1'b0};
    vecs[3] = '{1'b0, 10'd480,  8'hF8, 8'h03, 9'd0,   1'b1, 1'b0};
    vecs[4] = '{1'b1, 10'h3F0,  8'h10, 8'h25, 9'd8,   1'b1, 1'b0};
    vecs[5] = '{1'b0, 10'h123,  8'h37, 8'h40, 9'd100, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset pxl", {25'd0, pxl}, 32'd0);
    check("reset rom_cs", {31'd0, rom_cs}, 32'd0);
    check("reset miss", {31'd0, miss}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 1024; i++) begin
        w = 16'h2005 + 16'(i) * 16'h2107;
        map_m[i] = w;
        cpu_write(11'(i), w[7:0]);
        cpu_write(11'(i) | 11'h400, w[15:8]);
    end
    cpu_read(11'h000, rb); check("cpu rd w0 lo", {24'd0, rb}, 32'h05);
    cpu_read(11'h400, rb); check("cpu rd w0 hi", {24'd0, rb}, 32'h20);

    for (int vi = 0; vi < 6; vi++) begin
        flip = vecs[vi].flip; hscr = vecs[vi].hscr; vscr = vecs[vi].vscr;
        v = vecs[vi].v; h = vecs[vi].h0; rom_hash = vecs[vi].hash;
        for (int i = 0; i < 48; i++) pix_step(i >= 16);
        check("vec miss", {31'd0, miss}, {31'd0, vecs[vi].exp_miss});
    end

    cpu_write(11'h403, 8'hAB);
    cpu_write(11'h003, 8'hCD);
    map_m[3] = 16'hABCD;
    cpu_read(11'h403, rb); check("cpu rd w3 hi", {24'd0, rb}, 32'hAB);
    cpu_read(11'h003, rb); check("cpu rd w3 lo", {24'd0, rb}, 32'hCD);

    // scan of word 3 (row 0, hsum 48..63) picks up code 0x3CD, palette 5
    flip = 1'b0; hscr = 10'd512; vscr = 8'h00; v = 8'h05; h = 9'd16; rom_hash = 1'b1;
    for (int i = 0; i < 48; i++) begin
        hh = h;
        if (hh == 9'd42) begin
            check("w3 code", {21'd0, rom_addr[15:5]}, 32'h3CD);
            check("w3 rom_cs", {31'd0, rom_cs}, 32'd1);
        end
        pix_step(i >= 16);
        if (hh == 9'd52) check("w3 palette", {29'd0, last_pxl[6:4]}, 32'd5);
    end

    // rom_ok low across exactly one LOAD (hsum 31): group 32..39 goes transparent
    v = 8'h00; h = 9'd0;
    for (int i = 0; i < 56; i++) begin
        hh = h;
        rom_ok = (hh >= 9'd30 && hh <= 9'd33) ? 1'b0 : 1'b1;
        if (hh == 9'd30) check("miss before", {31'd0, miss}, 32'd0);
        pix_step(i >= 16);
        if (hh == 9'd35) check("late rom colour", {28'd0, last_pxl[3:0]}, 32'd0);
    end
    rom_ok = 1'b1;
    check("miss sticky", {31'd0, miss}, 32'd1);
    for (int i = 0; i < 11; i++) pix_step(1'b1);
    check("miss held", {31'd0, miss}, 32'd1);

    // asynchronous reset mid-group, checked before any clock edge
    #3 rst = 1'b1;
    #1;
    check("async pxl", {25'd0, pxl}, 32'd0);
    check("async rom_cs", {31'd0, rom_cs}, 32'd0);
    check("async miss", {31'd0, miss}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    pix_step(1'b0);
    check("post-reset pxl", {25'd0, last_pxl}, 32'd0);
    for (int i = 1; i < 40; i++) pix_step(i >= 16);
    check("post-reset miss", {31'd0, miss}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
end

endmodule
